// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - buffered 1-to-2 valid/ready stream demux, one 2-entry FIFO per branch
// Optional per-branch delivery counters cnt0/cnt1 when STREAM_DEMUX_CNT_EN is defined.
module stream_demux #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [W-1:0]     in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [W-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [W-1:0]     out1_data
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic [W-1:0] r_mem [2][2];
  logic [1:0]   r_occ [2];
  logic [1:0]   r_wptr;
  logic [1:0]   r_rptr;
  logic [1:0]   w_valid;
  logic [1:0]   w_push;
  logic [1:0]   w_pop;
  logic [1:0]   w_out_ready;
  logic         w_accept;

  assign in_ready    = !rst && (r_occ[in_sel] != 2'd2);
  assign w_accept    = in_valid && in_ready;
  assign w_out_ready = {out1_ready, out0_ready};

  always_comb begin
    w_valid = 2'b00;
    w_pop   = 2'b00;
    w_push  = {w_accept & in_sel, w_accept & ~in_sel};
    for (int k = 0; k < 2; k++) begin
      w_valid[k] = (r_occ[k] != 2'd0);
      w_pop[k]   = w_valid[k] & w_out_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        r_mem[k][0] <= '0;
        r_mem[k][1] <= '0;
        r_occ[k]    <= 2'd0;
      end
      r_wptr <= 2'b00;
      r_rptr <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wptr[k]] <= in_data;
          r_wptr[k]           <= ~r_wptr[k];
        end
        if (w_pop[k]) begin
          r_rptr[k] <= ~r_rptr[k];
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_occ[k] <= r_occ[k] + 2'd1;
          2'b01:   r_occ[k] <= r_occ[k] - 2'd1;
          default: r_occ[k] <= r_occ[k];
        endcase
      end
    end
  end

  // While empty, the slot behind the read pointer still holds the last popped word.
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_valid[0] ? r_mem[0][r_rptr[0]] : r_mem[0][~r_rptr[0]];
  assign out1_data  = w_valid[1] ? r_mem[1][r_rptr[1]] : r_mem[1][~r_rptr[1]];

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop[0]) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_pop[1]) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  generate
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
  endgenerate
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench for stream_demux with queue-based reference model
// Counter checks are included when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;
  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sel = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;
  logic         in_ready;
  logic         out0_valid;
  logic         out1_valid;
  logic [W-1:0] out0_data;
  logic [W-1:0] out1_data;
`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  stream_demux #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] last0 = '0;
  logic [W-1:0] last1 = '0;
  int           pops0 = 0;
  int           pops1 = 0;
  bit           chk_en = 0;
  bit           acc = 0;
  bit           exp_ready;
  bit           rnd_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state reflects DUT registers; check outputs, then advance model for the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ready = !rst && ((in_sel ? q1.size() : q0.size()) < 2);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
      else               chk("out0_hold", 32'(out0_data), 32'(last0));
      if (q1.size() > 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
      else               chk("out1_hold", 32'(out1_data), 32'(last1));
`ifdef STREAM_DEMUX_CNT_EN
      chk("cnt0", 32'(cnt0), 32'(pops0 % (1 << CNT_W)));
      chk("cnt1", 32'(cnt1), 32'(pops1 % (1 << CNT_W)));
`endif
      acc = in_valid && exp_ready;
      if (rst) begin
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        pops0 = 0;
        pops1 = 0;
      end else begin
        if (out0_ready && q0.size() > 0) begin
          last0 = q0.pop_front();
          pops0++;
        end
        if (out1_ready && q1.size() > 0) begin
          last1 = q1.pop_front();
          pops1++;
        end
        if (acc) begin
          if (in_sel) q1.push_back(in_data);
          else        q0.push_back(in_data);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc) begin
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h5555;
    @(posedge clk);
    #1;
    chk_en = 1;
    cycles(1);
    rst      = 1'b0;
    in_valid = 1'b0;

    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 16'h1111);
    send(1'b1, 16'h2222);
    cycles(3);

    out0_ready = 1'b0;
    send(1'b0, 16'h0a01);
    send(1'b0, 16'h0a02);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h0a03;
    cycles(3);
    in_valid = 1'b0;
    send(1'b1, 16'h0bb1);
    cycles(2);
    out0_ready = 1'b1;
    send(1'b0, 16'h0a03);
    cycles(4);

    out0_ready = 1'b0;
    send(1'b0, 16'h000a);
    send(1'b0, 16'h000b);
    out0_ready = 1'b1;
    send(1'b0, 16'h000c);
    cycles(4);

    out0_ready = 1'b0;
    send(1'b0, 16'h0d01);
    send(1'b0, 16'h0d02);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cycles(4);

`ifdef STREAM_DEMUX_CNT_EN
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send(1'b1, W'(16'h0c00 + i));
    cycles(3);
    chk("cnt1_wrap", 32'(cnt1), 32'd1);
    chk("cnt0_idle", 32'(cnt0), 32'd0);
`endif

    rnd_ready = 1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      send(1'($urandom_range(0, 1)), W'($urandom));
    end
    rnd_ready = 0;
    cycles(1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cycles(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
